// File: rtl/enc_pkg.sv
// Shared constants and the decode-result payload for the one-hot <-> binary codec pair.
package enc_pkg;

  localparam int unsigned ONEHOT_W_DEF = 15;
  localparam int unsigned BIN_W_DEF    = 4;
  localparam int unsigned CNT_W_DEF    = 8;

  // Code the encoder emits silently for "no bit set"; reused for all-zero inputs.
  localparam logic [BIN_W_DEF-1:0] ZERO_CODE = BIN_W_DEF'((1 << BIN_W_DEF) - 1);

  typedef struct packed {
    logic [BIN_W_DEF-1:0] idx;
    logic                 zero;
    logic                 err;
  } dec_res_t;

endpackage

// File: rtl/onehot_lowidx.sv
// Combinational lowest-set-bit index finder with all-zero and multi-hot detect.
module onehot_lowidx #(
  parameter int unsigned W     = 15,
  parameter int unsigned IDX_W = 4
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero,
  output logic             multi
);

  // Scan from the top down so the lowest set bit is the last writer.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign zero  = (vec == '0);
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(vec & (vec - W'(1)));

endmodule

// File: rtl/dec_onehot2bin.sv
// Two-stage one-hot to binary decoder with valid/ready backpressure and error status.
// Optional saturating error counter enabled by DEC_ONEHOT_ERR_CNT_EN.
module dec_onehot2bin
  import enc_pkg::*;
#(
  parameter int unsigned ONEHOT_W = ONEHOT_W_DEF,
  parameter int unsigned BIN_W    = BIN_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ONEHOT_W-1:0] in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    out,
  output logic                out_zero,
  output logic                out_err,
  output logic                err_sticky,
  input  logic                err_clr,
  output logic [CNT_W-1:0]    err_cnt
);

  logic                s1_valid;
  logic [ONEHOT_W-1:0] s1_vec;
  logic                s2_valid;
  dec_res_t            s2_res;
  dec_res_t            d_res;
  logic                s2_adv;
  logic                in_fire;
  logic                err_load;
  logic [BIN_W-1:0]    lo_idx;
  logic                lo_zero;
  logic                lo_multi;

  // Handshake: S2 drains or refills, S1 accepts whenever it will be empty.
  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_vec   <= in;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  onehot_lowidx #(
    .W     (ONEHOT_W),
    .IDX_W (BIN_W)
  ) u_lowidx (
    .vec   (s1_vec),
    .idx   (lo_idx),
    .zero  (lo_zero),
    .multi (lo_multi)
  );

  always_comb begin
    d_res      = '0;
    d_res.idx  = lo_zero ? ZERO_CODE : BIN_W_DEF'(lo_idx);
    d_res.zero = lo_zero;
    d_res.err  = lo_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_res   <= d_res;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out       = BIN_W'(s2_res.idx);
  assign out_zero  = s2_res.zero;
  assign out_err   = s2_res.err;

  assign err_load = s2_adv & d_res.err;

  // A new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_sticky <= 1'b0;
    else if (err_load) err_sticky <= 1'b1;
    else if (err_clr)  err_sticky <= 1'b0;
  end

`ifdef DEC_ONEHOT_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_load) begin
      if (err_clr)          cnt_q <= CNT_W'(1);
      else if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else if (err_clr) begin
      cnt_q <= '0;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dec_onehot2bin.sv
// Table-driven scoreboard bench for dec_onehot2bin.
module tb_dec_onehot2bin;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out;
  logic        out_zero;
  logic        out_err;
  logic        err_sticky;
  logic        err_clr;
  logic [7:0]  err_cnt;

  dec_onehot2bin dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    logic [14:0] vec;
    logic [3:0]  idx;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic       zero;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   errs;
  int   checks;
  int   cyc;
  int   last_lat;
  int   last_out_cyc;
  int   prev_out_cyc;
  logic [3:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output side of the scoreboard: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_output: got out=%0d with nothing pending", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {27'd0, out, out_zero, out_err}, {27'd0, e.idx, e.zero, e.err});
        last_lat     = cyc - e.cyc;
        prev_out_cyc = last_out_cyc;
        last_out_cyc = cyc;
      end
    end
  end

  task automatic wait_accept(input logic [3:0] idx, input logic zero, input logic err);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.idx = idx; e.zero = zero; e.err = err; e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [14:0] v, input logic [3:0] idx, input logic zero, input logic err);
    in_valid = 1'b1;
    in       = v;
    wait_accept(idx, zero, err);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    errs = 0; checks = 0; cyc = 0;
    last_lat = 0; last_out_cyc = 0; prev_out_cyc = 0;
    rst = 1'b1; in_valid = 1'b0; in = '0; out_ready = 1'b1; err_clr = 1'b0;

    tbl[0]  = '{15'h0001, 4'd0,  1'b0, 1'b0};
    tbl[1]  = '{15'h4000, 4'd14, 1'b0, 1'b0};
    tbl[2]  = '{15'h0020, 4'd5,  1'b0, 1'b0};
    tbl[3]  = '{15'h0000, 4'd15, 1'b1, 1'b0};
    tbl[4]  = '{15'h0012, 4'd1,  1'b0, 1'b1};
    tbl[5]  = '{15'h0003, 4'd0,  1'b0, 1'b1};
    tbl[6]  = '{15'h7FFF, 4'd0,  1'b0, 1'b1};
    tbl[7]  = '{15'h0400, 4'd10, 1'b0, 1'b0};
    tbl[8]  = '{15'h2000, 4'd13, 1'b0, 1'b0};
    tbl[9]  = '{15'h4001, 4'd0,  1'b0, 1'b1};
    tbl[10] = '{15'h0080, 4'd7,  1'b0, 1'b0};
    tbl[11] = '{15'h6000, 4'd13, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {26'd0, out_valid, out, out_zero, out_err}, 32'd0);
    chk("rst_sticky", {23'd0, err_sticky, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 32'd1);

    // First vector and its latency.
    send(15'h0001, 4'd0, 1'b0, 1'b0);
    drain();
    chk("latency", last_lat, 32'd2);

    // Back-to-back stream with no bubble.
    send(15'h4000, 4'd14, 1'b0, 1'b0);
    send(15'h0020, 4'd5,  1'b0, 1'b0);
    drain();
    chk("no_bubble", last_out_cyc - prev_out_cyc, 32'd1);

    // All-zero vector does not raise the error status.
    send(15'h0000, 4'd15, 1'b1, 1'b0);
    drain();
    chk("zero_no_sticky", err_sticky, 32'd0);

    // Multi-hot vector raises sticky and counter.
    send(15'h0012, 4'd1, 1'b0, 1'b1);
    drain();
    chk("multi_sticky", err_sticky, 32'd1);
`ifdef DEC_ONEHOT_ERR_CNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    chk("multi_cnt", err_cnt, exp_cnt);
    pulse_clr();
    chk("clr_sticky", err_sticky, 32'd0);
    chk("clr_cnt", err_cnt, 32'd0);

    // Table sweep.
    for (int i = 0; i < 12; i++) send(tbl[i].vec, tbl[i].idx, tbl[i].zero, tbl[i].err);
    drain();
    chk("table_sticky", err_sticky, 32'd1);
`ifdef DEC_ONEHOT_ERR_CNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    chk("table_cnt", err_cnt, exp_cnt);

    // Clear coinciding with a new error: the set wins and the count restarts at 1.
    send(15'h0003, 4'd0, 1'b0, 1'b1);
    pulse_clr();
    chk("clr_vs_set_sticky", err_sticky, 32'd1);
`ifdef DEC_ONEHOT_ERR_CNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    chk("clr_vs_set_cnt", err_cnt, exp_cnt);
    drain();

    // Stall: two vectors fill the pipe, the third waits.
    out_ready = 1'b0;
    send(15'h0008, 4'd3, 1'b0, 1'b0);
    send(15'h0100, 4'd8, 1'b0, 1'b0);
    in_valid = 1'b1;
    in       = 15'h1000;
    #1;
    chk("stall_in_ready", in_ready, 32'd0);
    chk("stall_valid", out_valid, 32'd1);
    held = out;
    chk("stall_first", held, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold", out, held);
    chk("stall_in_ready_hold", in_ready, 32'd0);
    out_ready = 1'b1;
    wait_accept(4'd12, 1'b0, 1'b0);
    drain();

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    send(15'h0001, 4'd0, 1'b0, 1'b0);
    send(15'h0002, 4'd1, 1'b0, 1'b0);
    chk("full_before_rst", out_valid, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 32'd0);
    chk("rst_mid_out", {28'd0, out}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_valid", out_valid, 32'd0);
    chk("no_stale_sticky", err_sticky, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
